// File: rtl/splt_cpu_regs_axil.sv
`timescale 1ns/1ps
// splt_cpu_regs_axil
//
// AXI4-Lite register window for the splt stream splitter. Seven 32-bit
// registers at word offsets from C_BASE_ADDRESS:
//   0x00 ID      RO   returns id_reg
//   0x04 VERSION RO   returns version_reg
//   0x08 RESET   RW   drives reset_reg, reads back reset_reg
//   0x0C FLIP    RW   write -> cpu2ip_flip_reg, read <- ip2cpu_flip_reg
//   0x10 DEBUG   RW   write -> cpu2ip_debug_reg, read <- ip2cpu_debug_reg
//   0x14 PKTIN   RO   returns pktin_reg, pulses pktin_reg_clear
//   0x18 PKTOUT  RO   returns pktout_reg, pulses pktout_reg_clear
// Anything else in the window answers DECERR (reads return 32'hDEADBEEF).
//
// Ports:
//   S_AXI_*                 AXI4-Lite slave, clocked by S_AXI_ACLK, async
//                           active-low reset S_AXI_ARESETN
//   id_reg .. pktout_reg    datapath values returned on reads
//   reset_reg, cpu2ip_*     CPU-written values
//   pkt*_reg_clear          single-cycle clear-on-read strobes
//   resetn_sync/resetn_soft synchronized copy of S_AXI_ARESETN
//   cpu_resetn_soft         resetn_sync gated by reset_reg[0]
//
// Build option: SPLT_CPU_REGS_WSTRB_EN -- when defined, writes honour
// S_AXI_WSTRB byte lanes; otherwise every accepted write updates all bits.

module splt_cpu_regs_axil #(
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     id_reg,
    input  logic [31:0]                     version_reg,
    output logic [31:0]                     reset_reg,
    input  logic [31:0]                     ip2cpu_flip_reg,
    output logic [31:0]                     cpu2ip_flip_reg,
    input  logic [31:0]                     ip2cpu_debug_reg,
    output logic [31:0]                     cpu2ip_debug_reg,
    input  logic [31:0]                     pktin_reg,
    output logic                            pktin_reg_clear,
    input  logic [31:0]                     pktout_reg,
    output logic                            pktout_reg_clear,
    output logic                            resetn_sync,
    output logic                            resetn_soft,
    output logic                            cpu_resetn_soft
);

    localparam int              AW   = C_S_AXI_ADDR_WIDTH;
    localparam int              DW   = C_S_AXI_DATA_WIDTH;
    localparam logic [AW-1:0]   BASE = AW'(C_BASE_ADDRESS);

    localparam logic [2:0] IDX_ID      = 3'd0;
    localparam logic [2:0] IDX_VERSION = 3'd1;
    localparam logic [2:0] IDX_RESET   = 3'd2;
    localparam logic [2:0] IDX_FLIP    = 3'd3;
    localparam logic [2:0] IDX_DEBUG   = 3'd4;
    localparam logic [2:0] IDX_PKTIN   = 3'd5;
    localparam logic [2:0] IDX_PKTOUT  = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic          awready_q, awready_d;
    logic          bvalid_q,  bvalid_d;
    logic [1:0]    bresp_q,   bresp_d;
    logic          arready_q, arready_d;
    logic          rvalid_q,  rvalid_d;
    logic [1:0]    rresp_q,   rresp_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic [31:0]   reset_reg_q, reset_reg_d;
    logic [31:0]   flip_q,      flip_d;
    logic [31:0]   debug_q,     debug_d;
    logic [1:0]    sync_q,      sync_d;

    logic [AW-1:0] wr_off, rd_off;
    logic [2:0]    wr_idx, rd_idx;
    logic          wr_hit, rd_hit;
    logic          wr_en,  rd_en;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_data;
    logic          unused_ok;

    // Byte offset into the window; bits [1:0] select nothing.
    assign wr_off = S_AXI_AWADDR - BASE;
    assign rd_off = S_AXI_ARADDR - BASE;
    assign wr_idx = wr_off[4:2];
    assign rd_idx = rd_off[4:2];
    assign wr_hit = (wr_off[AW-1:5] == '0) && (wr_idx != 3'd7);
    assign rd_hit = (rd_off[AW-1:5] == '0) && (rd_idx != 3'd7);

    // READY is only ever high for one cycle, so a transfer is taken exactly
    // on the edge where READY and VALID coincide.
    assign wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en   = arready_q & S_AXI_ARVALID;
    assign wr_data = S_AXI_WDATA;

`ifdef SPLT_CPU_REGS_WSTRB_EN
    assign wr_mask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                      {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
`else
    assign wr_mask = 32'hFFFF_FFFF;
`endif

    assign unused_ok = &{1'b0, wr_off[1:0], rd_off[1:0], S_AXI_WSTRB};

    always_comb begin
        awready_d   = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        reset_reg_d = reset_reg_q;
        flip_d      = flip_q;
        debug_d     = debug_q;

        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_hit ? RESP_OKAY : RESP_DECERR;
            if (wr_hit) begin
                case (wr_idx)
                    IDX_RESET: reset_reg_d = (reset_reg_q & ~wr_mask) | (wr_data & wr_mask);
                    IDX_FLIP:  flip_d      = (flip_q      & ~wr_mask) | (wr_data & wr_mask);
                    IDX_DEBUG: debug_d     = (debug_q     & ~wr_mask) | (wr_data & wr_mask);
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        arready_d        = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d         = rvalid_q;
        rresp_d          = rresp_q;
        rdata_d          = rdata_q;
        pktin_reg_clear  = 1'b0;
        pktout_reg_clear = 1'b0;

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_DECERR;
            if (!rd_hit) begin
                rdata_d = 32'hDEAD_BEEF;
            end else begin
                case (rd_idx)
                    IDX_ID:      rdata_d = id_reg;
                    IDX_VERSION: rdata_d = version_reg;
                    IDX_RESET:   rdata_d = reset_reg_q;
                    IDX_FLIP:    rdata_d = ip2cpu_flip_reg;
                    IDX_DEBUG:   rdata_d = ip2cpu_debug_reg;
                    IDX_PKTIN:   rdata_d = pktin_reg;
                    IDX_PKTOUT:  rdata_d = pktout_reg;
                    default:     rdata_d = 32'hDEAD_BEEF;
                endcase
                // The strobe coincides with the capture edge, so the datapath
                // clears exactly the value that was returned.
                pktin_reg_clear  = (rd_idx == IDX_PKTIN);
                pktout_reg_clear = (rd_idx == IDX_PKTOUT);
            end
        end
    end

    assign sync_d = {sync_q[0], 1'b1};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            reset_reg_q <= '0;
            flip_q      <= '0;
            debug_q     <= '0;
            sync_q      <= 2'b00;
        end else begin
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            reset_reg_q <= reset_reg_d;
            flip_q      <= flip_d;
            debug_q     <= debug_d;
            sync_q      <= sync_d;
        end
    end

    assign S_AXI_AWREADY    = awready_q;
    assign S_AXI_WREADY     = awready_q;
    assign S_AXI_BVALID     = bvalid_q;
    assign S_AXI_BRESP      = bresp_q;
    assign S_AXI_ARREADY    = arready_q;
    assign S_AXI_RVALID     = rvalid_q;
    assign S_AXI_RRESP      = rresp_q;
    assign S_AXI_RDATA      = rdata_q;
    assign reset_reg        = reset_reg_q;
    assign cpu2ip_flip_reg  = flip_q;
    assign cpu2ip_debug_reg = debug_q;
    assign resetn_sync      = sync_q[1];
    assign resetn_soft      = sync_q[1];
    assign cpu_resetn_soft  = sync_q[1] & ~reset_reg_q[0];

endmodule

// File: tb/tb_splt_cpu_regs_axil.sv
`timescale 1ns/1ps
module tb_splt_cpu_regs_axil;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] id_reg = 32'h5350_4C54, version_reg = 32'h0001_0002;
    logic [31:0] ip_flip = '0, ip_debug = '0, pktin = '0, pktout = '0;
    logic [31:0] reset_reg, cpu_flip, cpu_debug;
    logic        pktin_clear, pktout_clear, resetn_sync, resetn_soft, cpu_resetn_soft;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    splt_cpu_regs_axil dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .id_reg(id_reg), .version_reg(version_reg), .reset_reg(reset_reg),
        .ip2cpu_flip_reg(ip_flip), .cpu2ip_flip_reg(cpu_flip),
        .ip2cpu_debug_reg(ip_debug), .cpu2ip_debug_reg(cpu_debug),
        .pktin_reg(pktin), .pktin_reg_clear(pktin_clear),
        .pktout_reg(pktout), .pktout_reg_clear(pktout_clear),
        .resetn_sync(resetn_sync), .resetn_soft(resetn_soft), .cpu_resetn_soft(cpu_resetn_soft)
    );

    // Drives one write; b_wait counts extra cycles before BVALID (0 = next cycle).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int b_wait);
        int n;
        resp = 2'b00;
        b_wait = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        if (!awready) begin
            total++; bad++;
            $display("FAIL aw_timeout addr=%h awready=%b required=1", addr, awready);
            awvalid = 1'b0; wvalid = 1'b0; b_wait = 99;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && b_wait < 20) begin @(negedge clk); b_wait++; end
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Drives one read, holding RREADY low for 'stall' cycles after RVALID.
    task automatic axi_read(input logic [31:0] addr, input int stall,
                            output logic [31:0] data, output logic [1:0] resp, output int r_wait,
                            output int in_clr, output int out_clr, output bit stable);
        int n;
        logic [31:0] first;
        data = '0; resp = 2'b00; r_wait = 0; in_clr = 0; out_clr = 0; stable = 1'b1;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
            in_clr += int'(pktin_clear); out_clr += int'(pktout_clear);
        end while (!arready && n < 20);
        if (!arready) begin
            total++; bad++;
            $display("FAIL ar_timeout addr=%h arready=%b required=1", addr, arready);
            arvalid = 1'b0; r_wait = 99;
            return;
        end
        @(negedge clk);
        in_clr += int'(pktin_clear); out_clr += int'(pktout_clear);
        arvalid = 1'b0;
        while (!rvalid && r_wait < 20) begin
            @(negedge clk); r_wait++;
            in_clr += int'(pktin_clear); out_clr += int'(pktout_clear);
        end
        first = rdata;
        repeat (stall) begin
            @(negedge clk);
            in_clr += int'(pktin_clear); out_clr += int'(pktout_clear);
            if (!rvalid || rdata !== first) stable = 1'b0;
        end
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        in_clr += int'(pktin_clear); out_clr += int'(pktout_clear);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({awready, wready, bvalid, arready, rvalid, pktin_clear, pktout_clear,
             resetn_sync, resetn_soft, cpu_resetn_soft} !== 10'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b required=0", {awready, wready, bvalid, arready,
                 rvalid, pktin_clear, pktout_clear, resetn_sync, resetn_soft, cpu_resetn_soft});
        end
        total++;
        if ({rdata, bresp, rresp} !== 36'h0) begin
            bad++; $display("FAIL reset_data rdata=%h bresp=%b rresp=%b required=0", rdata, bresp, rresp);
        end
        total++;
        if ({reset_reg, cpu_flip, cpu_debug} !== 96'h0) begin
            bad++; $display("FAIL reset_regs reset=%h flip=%h debug=%h required=0", reset_reg, cpu_flip, cpu_debug);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (resetn_sync !== 1'b0) begin
            bad++; $display("FAIL sync_edge1 got=%b required=0", resetn_sync);
        end
        @(negedge clk);
        total++;
        if ({resetn_sync, resetn_soft, cpu_resetn_soft} !== 3'b111) begin
            bad++; $display("FAIL sync_edge2 got=%b required=111", {resetn_sync, resetn_soft, cpu_resetn_soft});
        end
    endtask

    task automatic test_id_read();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        axi_read(32'h00, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'h5350_4C54 || r !== 2'b00 || w !== 0) begin
            bad++; $display("FAIL id_read data=%h resp=%b wait=%0d required 53504c54/00/0", d, r, w);
        end
        axi_read(32'h04, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'h0001_0002 || r !== 2'b00) begin
            bad++; $display("FAIL version_read data=%h resp=%b required 00010002/00", d, r);
        end
    endtask

    task automatic test_flip();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        axi_write(32'h0C, 32'hA5A5_0F0F, 4'hF, r, w);
        total++;
        if (cpu_flip !== 32'hA5A5_0F0F || r !== 2'b00 || w !== 0) begin
            bad++; $display("FAIL flip_write flip=%h bresp=%b wait=%0d required a5a50f0f/00/0", cpu_flip, r, w);
        end
        ip_flip = 32'h0000_1234;
        axi_read(32'h0C, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'h0000_1234 || r !== 2'b00) begin
            bad++; $display("FAIL flip_read data=%h resp=%b required 00001234/00", d, r);
        end
        // Byte address 0x0F still selects FLIP since bits [1:0] are ignored.
        axi_write(32'h0F, 32'h5A5A_5A5A, 4'hF, r, w);
        total++;
        if (cpu_flip !== 32'h5A5A_5A5A || r !== 2'b00) begin
            bad++; $display("FAIL flip_lowbits flip=%h bresp=%b required 5a5a5a5a/00", cpu_flip, r);
        end
    endtask

    task automatic test_debug_wstrb();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        logic [31:0] exp_dbg;
`ifdef SPLT_CPU_REGS_WSTRB_EN
        exp_dbg = 32'h0000_FF00;
`else
        exp_dbg = 32'hFFFF_FFFF;
`endif
        axi_write(32'h10, 32'hFFFF_FFFF, 4'b0010, r, w);
        total++;
        if (cpu_debug !== exp_dbg || r !== 2'b00) begin
            bad++; $display("FAIL debug_wstrb debug=%h bresp=%b required %h/00", cpu_debug, r, exp_dbg);
        end
        ip_debug = 32'hCAFE_0001;
        axi_read(32'h10, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'hCAFE_0001) begin
            bad++; $display("FAIL debug_read data=%h required cafe0001", d);
        end
    endtask

    task automatic test_ro_write();
        logic [1:0] r; int w;
        axi_write(32'h00, 32'h1111_1111, 4'hF, r, w);
        total++;
        if (r !== 2'b00 || cpu_flip !== 32'h5A5A_5A5A || reset_reg !== 32'h0) begin
            bad++; $display("FAIL ro_write bresp=%b flip=%h reset=%h required 00/5a5a5a5a/0", r, cpu_flip, reset_reg);
        end
    endtask

    task automatic test_pkt();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        pktin = 32'd77;
        axi_read(32'h14, 5, d, r, w, ci, co, st);
        total++;
        if (d !== 32'd77 || r !== 2'b00 || w !== 0) begin
            bad++; $display("FAIL pktin_read data=%0d resp=%b wait=%0d required 77/00/0", d, r, w);
        end
        total++;
        if (ci !== 1 || co !== 0) begin
            bad++; $display("FAIL pktin_clear in_pulses=%0d out_pulses=%0d required 1/0", ci, co);
        end
        total++;
        if (st !== 1'b1) begin
            bad++; $display("FAIL rdata_stable stable=%b required 1", st);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        pktout = 32'd99;
        axi_read(32'h18, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'd99 || ci !== 0 || co !== 1) begin
            bad++; $display("FAIL pktout_1 data=%0d in=%0d out=%0d required 99/0/1", d, ci, co);
        end
        pktout = 32'd3;
        axi_read(32'h18, 2, d, r, w, ci, co, st);
        total++;
        if (d !== 32'd3 || ci !== 0 || co !== 1) begin
            bad++; $display("FAIL pktout_2 data=%0d in=%0d out=%0d required 3/0/1", d, ci, co);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        axi_read(32'h40, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b11 || ci !== 0 || co !== 0) begin
            bad++; $display("FAIL unmapped_read data=%h resp=%b clr=%0d/%0d required deadbeef/11/0/0", d, r, ci, co);
        end
        axi_read(32'h1C, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b11) begin
            bad++; $display("FAIL edge_1c_read data=%h resp=%b required deadbeef/11", d, r);
        end
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, r, w);
        total++;
        if (r !== 2'b11 || cpu_flip !== 32'h5A5A_5A5A || reset_reg !== 32'h0) begin
            bad++; $display("FAIL unmapped_write bresp=%b flip=%h reset=%h required 11/5a5a5a5a/0", r, cpu_flip, reset_reg);
        end
    endtask

    task automatic test_soft_reset();
        logic [31:0] d; logic [1:0] r; int w, ci, co; bit st;
        axi_write(32'h08, 32'h1, 4'hF, r, w);
        total++;
        if (reset_reg !== 32'h1 || cpu_resetn_soft !== 1'b0 || resetn_soft !== 1'b1) begin
            bad++; $display("FAIL soft_assert reset=%h cpu_soft=%b soft=%b required 1/0/1", reset_reg, cpu_resetn_soft, resetn_soft);
        end
        axi_read(32'h08, 0, d, r, w, ci, co, st);
        total++;
        if (d !== 32'h1 || r !== 2'b00) begin
            bad++; $display("FAIL reset_readback data=%h resp=%b required 1/00", d, r);
        end
        axi_write(32'h08, 32'h0, 4'hF, r, w);
        total++;
        if (cpu_resetn_soft !== 1'b1) begin
            bad++; $display("FAIL soft_release cpu_soft=%b required 1", cpu_resetn_soft);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        awaddr = 32'h0C; wdata = 32'hFFFF_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk); n++;
            if (awready) begin @(negedge clk); n++; awvalid = 1'b0; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1 || cpu_flip !== 32'hFFFF_0000) begin
            bad++; $display("FAIL mid_pre bvalid=%b flip=%h required 1/ffff0000", bvalid, cpu_flip);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bvalid !== 1'b0 || resetn_sync !== 1'b0 || cpu_resetn_soft !== 1'b0 || cpu_flip !== 32'h0) begin
            bad++; $display("FAIL mid_reset bvalid=%b sync=%b cpu_soft=%b flip=%h required 0/0/0/0",
                            bvalid, resetn_sync, cpu_resetn_soft, cpu_flip);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (resetn_sync !== 1'b0 || bvalid !== 1'b0) begin
            bad++; $display("FAIL mid_edge1 sync=%b bvalid=%b required 0/0", resetn_sync, bvalid);
        end
        @(negedge clk);
        total++;
        if (resetn_sync !== 1'b1 || cpu_resetn_soft !== 1'b1) begin
            bad++; $display("FAIL mid_edge2 sync=%b cpu_soft=%b required 1/1", resetn_sync, cpu_resetn_soft);
        end
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_flip();
        test_debug_wstrb();
        test_ro_write();
        test_pkt();
        test_back_to_back();
        test_unmapped();
        test_soft_reset();
        test_reset_mid();
        test_id_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/splt_cpu_regs_axil.md
# splt_cpu_regs_axil

AXI4-Lite slave register file for the `splt` stream splitter. It exposes seven 32-bit registers to the host CPU: ID, VERSION, RESET, FLIP, DEBUG, PKTIN and PKTOUT. It drives CPU-written values and clear-on-read pulses into the datapath, and returns datapath-supplied values on reads. It also generates the synchronized and soft resets used by the splitter.

## Interface
Parameters:
- C_BASE_ADDRESS, 32'h00000000, byte base address of the register window
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width

Ports:
- S_AXI_ACLK  in  1  the only clock; clocks all logic
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR/ARADDR  in  ADDR_W  write/read byte address
- S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY  in  1  AXI handshakes
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID  out  1  AXI handshakes
- S_AXI_BRESP/RRESP  out  2  responses
- S_AXI_RDATA  out  32  read data
- id_reg, version_reg, ip2cpu_flip_reg, ip2cpu_debug_reg, pktin_reg, pktout_reg  in  32  values returned on reads
- reset_reg, cpu2ip_flip_reg, cpu2ip_debug_reg  out  32  CPU-written values
- pktin_reg_clear, pktout_reg_clear  out  1  one-cycle clear-on-read pulses
- resetn_sync  out  1  synchronized reset
- resetn_soft  out  1  soft reset to the CPU module
- cpu_resetn_soft  out  1  software-controlled reset

## Operation
- Address decoding: offset = ADDR − C_BASE_ADDRESS; bits [1:0] are ignored.
- Register map:
  - 0x00 ID, RO
  - 0x04 VERSION, RO
  - 0x08 RESET, RW
  - 0x0C FLIP, RW
  - 0x10 DEBUG, RW
  - 0x14 PKTIN, RO clear-on-read
  - 0x18 PKTOUT, RO clear-on-read
- Offsets outside 0x00–0x1B are unmapped.
- FLIP and DEBUG:
  - A write updates cpu2ip_*_reg.
  - A read returns ip2cpu_*_reg, not the written value.
- RESET: a write updates reset_reg; a read returns reset_reg.
- ID, VERSION, PKTIN, PKTOUT: writes are accepted with BRESP OKAY and have no effect.
- PKTIN/PKTOUT read:
  - RDATA captures the pktin_reg/pktout_reg value in the cycle the address is accepted.
  - The matching *_clear output pulses high for exactly that one cycle.
- Unmapped access:
  - Read returns RDATA 32'hDEADBEEF, RRESP 2'b11 (DECERR).
  - Write is ignored, BRESP 2'b11.
- Mapped accesses respond OKAY (2'b00).
- Reset outputs:
  - resetn_sync: 2-flop synchronizer; asserts asynchronously, deasserts on the 2nd rising edge after S_AXI_ARESETN rises.
  - resetn_soft = resetn_sync.
  - cpu_resetn_soft = resetn_sync & ~reset_reg[0].
- Reset values:
  - reset_reg = 0, cpu2ip_flip_reg = 0, cpu2ip_debug_reg = 0.
  - All AXI VALID/READY outputs low, RDATA 0, responses 0, clear pulses 0.

## Timing
- Write channel:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & ~BVALID.
  - The register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & ~RVALID.
  - RDATA/RRESP are registered; RVALID rises the next cycle and holds until RREADY.
  - RDATA is stable while RVALID is high.
- One outstanding transaction per channel.
- Read and write may proceed in the same cycle independently.
- Simultaneous write to FLIP and read of FLIP: the read returns ip2cpu_flip_reg, so there is no hazard.
- A clear pulse is generated only on address acceptance, never repeated while RVALID stalls.
- Reset mid-transaction:
  - All handshake state clears immediately.
  - The pending response is dropped.

## Configuration
- SPLT_CPU_REGS_WSTRB_EN:
  - Defined: writes honor S_AXI_WSTRB; only bytes with strobe = 1 update.
  - Undefined: WSTRB is ignored and every accepted write updates all 32 bits.

## Test plan
- Reset, then read ID with id_reg = 32'h53504C54 → RVALID one cycle after ARREADY, RDATA 32'h53504C54, RRESP 0.
- Write 32'hA5A5_0F0F to 0x0C → cpu2ip_flip_reg = A5A50F0F after the AW/W handshake; BRESP 0; a read of 0x0C returns ip2cpu_flip_reg (drive 32'h1234 → read 32'h1234).
- Read 0x14 with pktin_reg = 32'd77 → RDATA 77, pktin_reg_clear high exactly one cycle; holding RREADY low 5 cycles produces no second pulse.
- Read and write offset 0x40 → RDATA DEADBEEF, RRESP 2'b11; BRESP 2'b11; no output register changes.
- Write 0x1 to RESET (0x08) → cpu_resetn_soft goes low; write 0x0 → high; pulse S_AXI_ARESETN low mid-write → BVALID clears, resetn_sync low immediately, high 2 edges after release.
- With SPLT_CPU_REGS_WSTRB_EN defined, write FFFFFFFF with WSTRB 4'b0010 to DEBUG (previously 0) → cpu2ip_debug_reg = 32'h0000FF00.
